// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU write-back constants
package fpu_pkg;
  localparam int DEPTH = 2;
  localparam int FLAG_W = 5;
  localparam int RES_W = 64;
endpackage

// File: rtl/fpu_skid2.sv
// fpu_skid2: 2-entry in-order FIFO storage with 1-bit pointers
module fpu_skid2
  import fpu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic wptr, rptr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '{default: '0};
      wptr <= 1'b0;
      rptr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end
  assign dout = mem[rptr];
endmodule

// File: rtl/fpadd_wb.sv
// fpadd_wb: buffers fpadd results for register-file write-back and accumulates retired flags
module fpadd_wb
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RES_W-1:0]  AS_Result,
  input  logic [FLAG_W-1:0] Flags,
  input  logic              Denorm,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_denorm,
  input  logic              flags_clr,
  output logic [FLAG_W-1:0] acc_flags
);
  localparam int W = RES_W + FLAG_W + 1 + TAG_W;
  logic [W-1:0] head;
  logic [FLAG_W-1:0] head_flags;
  logic [1:0] count;
  logic en, push, pop;
  // en holds in_ready low until the first edge after reset releases
  always_ff @(posedge clk or posedge reset) begin
    if (reset) en <= 1'b0;
    else en <= 1'b1;
  end
  assign in_ready = en & (count < 2'(DEPTH));
  assign out_valid = count != 2'd0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign {out_result, head_flags, out_denorm, out_tag} = head;
  fpu_skid2 #(.W(W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({AS_Result, Flags, Denorm, in_tag}),
    .dout  (head),
    .count (count)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_flags <= '0;
    else if (flags_clr | pop) acc_flags <= (flags_clr ? '0 : acc_flags) | (pop ? head_flags : '0);
  end
endmodule

// File: tb/tb_fpadd_wb.sv
// tb_fpadd_wb: queue-model bench with directed scenarios and random traffic
module tb_fpadd_wb;
  localparam int TAG_W = 5;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, flags_clr = 1'b0, Denorm = 1'b0;
  logic [63:0] AS_Result = '0;
  logic [4:0] Flags = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic in_ready, out_valid, out_denorm;
  logic [63:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic [4:0] acc_flags;
  int checks = 0, errs = 0;

  fpadd_wb #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .AS_Result(AS_Result), .Flags(Flags), .Denorm(Denorm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_denorm(out_denorm), .flags_clr(flags_clr),
    .acc_flags(acc_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [4:0] fl;
    logic dn;
    logic [TAG_W-1:0] tag;
  } ent_t;
  ent_t q[$];
  ent_t hd, ne;
  bit en_m = 0;
  logic [4:0] acc_m = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: compared at negedge, then advanced with the inputs that the next posedge will see
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      en_m = 0;
      acc_m = '0;
      if (!clk) begin
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc", acc_flags, 0);
      end
    end else begin
      bit p, o;
      chk("m_in_ready", in_ready, en_m && q.size() < 2);
      chk("m_out_valid", out_valid, q.size() > 0);
      chk("m_acc", acc_flags, acc_m);
      if (q.size() > 0) begin
        chk("m_result", out_result, q[0].res);
        chk("m_tag", out_tag, q[0].tag);
        chk("m_denorm", out_denorm, q[0].dn);
      end
      p = in_valid && en_m && q.size() < 2;
      o = out_ready && q.size() > 0;
      if (o) begin
        hd = q.pop_front();
        acc_m = flags_clr ? hd.fl : (acc_m | hd.fl);
      end else if (flags_clr) acc_m = '0;
      if (p) begin
        ne.res = AS_Result; ne.fl = Flags; ne.dn = Denorm; ne.tag = in_tag;
        q.push_back(ne);
      end
      en_m = 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [63:0] r, input logic [4:0] f, input logic [TAG_W-1:0] t);
    in_valid = v; AS_Result = r; Flags = f; in_tag = t; Denorm = r[0];
  endtask

  initial begin
    repeat (2) cyc();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    #2 reset = 0;
    cyc();
    chk("ready_after_release", in_ready, 1);
    // single op
    put(1, 64'h3FF0000000000000, 5'b00001, 3);
    out_ready = 1;
    cyc();
    put(0, 0, 0, 0);
    chk("single_valid", out_valid, 1);
    chk("single_result", out_result, 64'h3FF0000000000000);
    chk("single_tag", out_tag, 3);
    chk("single_acc_before", acc_flags, 0);
    cyc();
    chk("single_acc", acc_flags, 5'b00001);
    chk("single_empty", out_valid, 0);
    // backpressure
    out_ready = 0;
    put(1, 64'h11, 0, 1); cyc();
    put(1, 64'h22, 0, 2); cyc();
    chk("bp_full", in_ready, 0);
    put(1, 64'h77, 0, 7); cyc();
    put(0, 0, 0, 0);
    chk("bp_head1", out_tag, 1);
    out_ready = 1; cyc();
    chk("bp_head2", out_tag, 2);
    cyc();
    chk("bp_empty", out_valid, 0);
    out_ready = 0;
    // simultaneous push/pop at count 1
    put(1, 64'h44, 0, 4); cyc();
    put(1, 64'h55, 0, 5); out_ready = 1; cyc();
    chk("sim_tag5", out_tag, 5);
    chk("sim_ready", in_ready, 1);
    put(1, 64'h66, 0, 6); cyc();
    chk("sim_tag6", out_tag, 6);
    put(0, 0, 0, 0); cyc();
    chk("sim_empty", out_valid, 0);
    // flag accumulation
    out_ready = 0; flags_clr = 1; cyc();
    flags_clr = 0;
    chk("fl_clr", acc_flags, 0);
    put(1, 64'h88, 5'b00100, 8); cyc();
    put(1, 64'h99, 5'b10000, 9); cyc();
    put(0, 0, 0, 0);
    chk("fl_held", acc_flags, 0);
    out_ready = 1; cyc(); cyc();
    chk("fl_or", acc_flags, 5'b10100);
    out_ready = 0;
    put(1, 64'hAA, 5'b00010, 10); cyc();
    put(0, 0, 0, 0);
    out_ready = 1; flags_clr = 1; cyc();
    flags_clr = 0; out_ready = 0;
    chk("fl_clr_pop", acc_flags, 5'b00010);
    // reset mid-operation
    put(1, 64'hBB, 5'b01000, 11); cyc();
    put(1, 64'hCC, 5'b00001, 12); cyc();
    put(0, 0, 0, 0);
    chk("mid_full", out_valid, 1);
    #1 reset = 1;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_acc", acc_flags, 0);
    chk("mid_in_ready", in_ready, 0);
    #1 reset = 0;
    cyc();
    chk("mid_ready_edge", in_ready, 1);
    chk("mid_still_empty", out_valid, 0);
    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      put($urandom_range(0, 3) != 0, {$urandom, $urandom}, 5'($urandom), TAG_W'($urandom));
      out_ready = $urandom_range(0, 2) != 0;
      flags_clr = $urandom_range(0, 15) == 0;
      cyc();
    end
    put(0, 0, 0, 0);
    flags_clr = 0; out_ready = 1;
    repeat (4) cyc();
    chk("drained", out_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule

// File: doc/fpadd_wb.md
FPADD_WB -- requirements
Module: fpadd_wb

Interface
REQ-001 SHALL have parameter TAG_W, default 5, destination-register tag width.
REQ-002 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1; one clock, reset asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, fpadd result present this cycle.
REQ-005 SHALL have port in_ready, output, 1, stage can accept a result.
REQ-006 SHALL have port AS_Result, input, 64, fpadd result word.
REQ-007 SHALL have port Flags, input, 5, fpadd IEEE exception flags.
REQ-008 SHALL have port Denorm, input, 1, fpadd denorm indication.
REQ-009 SHALL have port in_tag, input, TAG_W, destination tag travelling with the operation.
REQ-010 SHALL have port out_valid, output, 1, head entry available.
REQ-011 SHALL have port out_ready, input, 1, register file accepts head entry.
REQ-012 SHALL have port out_result, output, 64, head entry result.
REQ-013 SHALL have port out_tag, output, TAG_W, head entry tag.
REQ-014 SHALL have port out_denorm, output, 1, head entry Denorm.
REQ-015 SHALL have port flags_clr, input, 1, synchronous clear of accumulated flags.
REQ-016 SHALL have port acc_flags, output, 5, sticky OR of flags of retired results.

Function
REQ-017 SHALL buffer results in a 2-entry in-order FIFO: entry = {AS_Result, Flags, Denorm, in_tag}.
REQ-018 SHALL accept (push) when in_valid & in_ready at a rising edge; in_ready = (count < 2), registered-state derived, no combinational path from out_ready.
REQ-019 SHALL retire (pop) the head when out_valid & out_ready at a rising edge; out_valid = (count > 0).
REQ-020 SHALL present a pushed entry on out_* the cycle after acceptance (latency 1); never combinational pass-through.
REQ-021 SHALL, on simultaneous push and pop at count 1, keep count 1 and present the new entry next cycle.
REQ-022 SHALL ignore in_valid when count = 2 (in_ready low); no overwrite, no data loss.
REQ-023 SHALL ignore out_ready when count = 0; count never underflows.
REQ-024 SHALL hold out_result, out_tag, out_denorm stable while out_valid & ~out_ready.
REQ-025 SHALL use 1-bit read/write pointers wrapping 1->0 and a 2-bit count (0..2).
REQ-026 SHALL update acc_flags only on pop: acc_flags <= acc_flags | head.Flags, bit order unchanged.
REQ-027 SHALL, on flags_clr, set acc_flags <= 0; if flags_clr and pop coincide, acc_flags <= head.Flags.
REQ-028 SHALL not alter acc_flags for entries held in the FIFO but not retired.

Reset
REQ-029 SHALL, while reset is high, force count 0, pointers 0, storage 0, acc_flags 0, out_valid 0, in_ready 0.
REQ-030 SHALL raise in_ready on the first clk edge after reset deasserts; reset mid-operation discards all buffered entries.

Structure
REQ-031 SHALL place FIFO depth (2), flag width (5), and result width (64) constants in shared package fpu_pkg.
REQ-032 SHALL implement storage/pointers as sub-module fpu_skid2, parameterised by entry width; flag accumulation stays in fpadd_wb.

Verification
REQ-033 SHALL verify single op: push AS_Result=0x3FF0000000000000, Flags=5'b00001, tag=3, out_ready=1 -> next cycle out_valid=1, out_result=0x3FF0000000000000, out_tag=3; following cycle acc_flags=5'b00001.
REQ-034 SHALL verify backpressure: out_ready=0, push tags 1,2 -> in_ready=0 after second push; third in_valid (tag 7) ignored; release out_ready -> tags 1,2 emerge in order, tag 7 never appears.
REQ-035 SHALL verify simultaneous push/pop at count 1: count stays 1, out_tag sequence uninterrupted, no duplicate or dropped tag.
REQ-036 SHALL verify flags: retire Flags 5'b00100 then 5'b10000 -> acc_flags=5'b10100; flags_clr with pop of 5'b00010 -> acc_flags=5'b00010.
REQ-037 SHALL verify reset mid-operation: two entries buffered, pulse reset asynchronously between edges -> out_valid=0, acc_flags=0 immediately; in_ready=1 on first edge after release.
